// File: rtl/team_06_pkg.sv
// Shared types and default constants for the team_06 voice control block.
package team_06_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LISTEN = 2'd1,
    TALK   = 2'd2,
    MUTE   = 2'd3
  } state_t;

  localparam int AUD_W_DEF      = 8;
  localparam int VAD_THRESH_DEF = 64;

endpackage

// File: rtl/team_06_edge_det.sv
// Registered rising-edge detector for a pre-synchronised level button.
module team_06_edge_det (
  input  logic clk,
  input  logic nrst,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) prev_q <= 1'b0;
    else       prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/team_06_voice_ctrl_fsm.sv
// Half-duplex voice arbiter: push-to-talk / voice-activated talk with hang timer,
// mute, noise-gate and effect-cycle buttons. Optional hysteresis via TEAM_06_VAD_HYST_EN.
module team_06_voice_ctrl_fsm
  import team_06_pkg::*;
#(
  parameter int AUD_W       = AUD_W_DEF,
  parameter int NUM_EFFECTS = 5,
  parameter int VAD_THRESH  = VAD_THRESH_DEF,
  parameter int VAD_HYST    = 8,
  parameter int HANG_CYCLES = 2048
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [AUD_W-1:0]               mic_aud,
  input  logic [AUD_W-1:0]               spk_aud,
  input  logic                           ng_en,
  input  logic                           ptt_en,
  input  logic                           effect,
  input  logic                           mute,
  output logic [1:0]                     state,
  output logic                           eff_en,
  output logic                           vol_en,
  output logic [$clog2(NUM_EFFECTS)-1:0] current_effect,
  output logic                           mute_tog,
  output logic                           noise_gate_tog
);

  localparam int EFF_W = $clog2(NUM_EFFECTS);
  localparam int CNT_W = (HANG_CYCLES > 0) ? $clog2(HANG_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] HANG_LD  = CNT_W'(HANG_CYCLES);
  localparam logic [EFF_W-1:0] EFF_LAST = EFF_W'(NUM_EFFECTS - 1);
  localparam logic [AUD_W-1:0] OPEN_LVL = AUD_W'(VAD_THRESH);

  if (NUM_EFFECTS < 2 || VAD_HYST > VAD_THRESH) begin : g_bad_cfg
    $error("team_06_voice_ctrl_fsm: NUM_EFFECTS must be >= 2 and VAD_HYST <= VAD_THRESH");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  hang_q, hang_d;
  logic [EFF_W-1:0]  eff_q, eff_d;
  logic              mute_tog_q, mute_tog_d;
  logic              ng_tog_q, ng_tog_d;
  logic              mute_rise, ng_rise, eff_rise;
  logic              vad_open, talk_req, spk_act;

  team_06_edge_det u_mute_ed (.clk(clk), .nrst(nrst), .btn_i(mute),   .rise_o(mute_rise));
  team_06_edge_det u_ng_ed   (.clk(clk), .nrst(nrst), .btn_i(ng_en),  .rise_o(ng_rise));
  team_06_edge_det u_eff_ed  (.clk(clk), .nrst(nrst), .btn_i(effect), .rise_o(eff_rise));

`ifdef TEAM_06_VAD_HYST_EN
  localparam logic [AUD_W-1:0] CLOSE_LVL = AUD_W'(VAD_THRESH - VAD_HYST);
  logic vad_q, vad_d;

  always_comb begin
    vad_d = vad_q;
    if (!ng_tog_q)                vad_d = 1'b0;
    else if (mic_aud >= OPEN_LVL) vad_d = 1'b1;
    else if (mic_aud < CLOSE_LVL) vad_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) vad_q <= 1'b0;
    else       vad_q <= vad_d;
  end

  assign vad_open = vad_q;
`else
  assign vad_open = ng_tog_q & (mic_aud >= OPEN_LVL);
`endif

  assign talk_req = ptt_en | vad_open;
  assign spk_act  = (spk_aud != '0);

  always_comb begin
    mute_tog_d = mute_tog_q ^ mute_rise;
    ng_tog_d   = ng_tog_q ^ ng_rise;
    eff_d      = eff_q;
    if (eff_rise) eff_d = (eff_q == EFF_LAST) ? '0 : eff_q + 1'b1;
  end

  // Mute reacts on the cycle after the toggle latches, since it is taken from the register.
  always_comb begin
    state_d = state_q;
    hang_d  = hang_q;
    if (mute_tog_q) begin
      state_d = MUTE;
    end else begin
      case (state_q)
        MUTE: state_d = IDLE;
        IDLE: begin
          if (talk_req) begin
            state_d = TALK;
            hang_d  = HANG_LD;
          end else if (spk_act) begin
            state_d = LISTEN;
          end
        end
        LISTEN: begin
          if (talk_req) begin
            state_d = TALK;
            hang_d  = HANG_LD;
          end else if (!spk_act) begin
            state_d = IDLE;
          end
        end
        TALK: begin
          if (talk_req)           hang_d  = HANG_LD;
          else if (hang_q == '0)  state_d = spk_act ? LISTEN : IDLE;
          else                    hang_d  = hang_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      hang_q     <= '0;
      eff_q      <= '0;
      mute_tog_q <= 1'b0;
      ng_tog_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hang_q     <= hang_d;
      eff_q      <= eff_d;
      mute_tog_q <= mute_tog_d;
      ng_tog_q   <= ng_tog_d;
    end
  end

  assign state          = state_q;
  assign eff_en         = (state_q == TALK) && (eff_q != '0);
  assign vol_en         = (state_q == LISTEN);
  assign current_effect = eff_q;
  assign mute_tog       = mute_tog_q;
  assign noise_gate_tog = ng_tog_q;

endmodule

// File: tb/tb_team_06_voice_ctrl_fsm.sv
// Self-checking bench for team_06_voice_ctrl_fsm (HANG_CYCLES=4) with a behavioural model.
module tb_team_06_voice_ctrl_fsm;

  localparam int H    = 4;
  localparam int NEFF = 5;
  localparam int THR  = 64;
  localparam int HYS  = 8;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] mic_aud = '0, spk_aud = '0;
  logic       ng_en = 1'b0, ptt_en = 1'b0, effect = 1'b0, mute = 1'b0;
  logic [1:0] state;
  logic       eff_en, vol_en, mute_tog, noise_gate_tog;
  logic [2:0] current_effect;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  team_06_voice_ctrl_fsm #(
    .AUD_W(8), .NUM_EFFECTS(NEFF), .VAD_THRESH(THR), .VAD_HYST(HYS), .HANG_CYCLES(H)
  ) dut (
    .clk(clk), .nrst(nrst), .mic_aud(mic_aud), .spk_aud(spk_aud),
    .ng_en(ng_en), .ptt_en(ptt_en), .effect(effect), .mute(mute),
    .state(state), .eff_en(eff_en), .vol_en(vol_en), .current_effect(current_effect),
    .mute_tog(mute_tog), .noise_gate_tog(noise_gate_tog)
  );

  always #5 clk = ~clk;

  // Behavioural model: counts button rises and quiet cycles instead of mirroring registers.
  int m_mode = 0;
  int m_quiet = 0;
  int m_mute_rises = 0, m_ng_rises = 0, m_eff_rises = 0;
  bit m_pmute = 0, m_png = 0, m_peff = 0;
  bit m_vad = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_mode = 0; m_quiet = 0;
      m_mute_rises = 0; m_ng_rises = 0; m_eff_rises = 0;
      m_pmute = 0; m_png = 0; m_peff = 0; m_vad = 0;
    end else begin
      bit muted, gate, vad, talk, spk;
      muted = (m_mute_rises % 2) == 1;
      gate  = (m_ng_rises % 2) == 1;
`ifdef TEAM_06_VAD_HYST_EN
      vad = m_vad;
      if (!gate)                 m_vad = 0;
      else if (int'(mic_aud) >= THR)       m_vad = 1;
      else if (int'(mic_aud) < THR - HYS)  m_vad = 0;
`else
      vad = gate && (int'(mic_aud) >= THR);
`endif
      talk = ptt_en || vad;
      spk  = (spk_aud != 0);
      if (talk) m_quiet = 0;
      else if (m_quiet <= H) m_quiet++;
      if (muted) m_mode = 3;
      else if (m_mode == 3) m_mode = 0;
      else if (m_mode == 0) m_mode = talk ? 2 : (spk ? 1 : 0);
      else if (m_mode == 1) m_mode = talk ? 2 : (spk ? 1 : 0);
      else if (m_quiet > H) m_mode = spk ? 1 : 0;
      if (mute && !m_pmute)  m_mute_rises++;
      if (ng_en && !m_png)   m_ng_rises++;
      if (effect && !m_peff) m_eff_rises++;
      m_pmute = mute; m_png = ng_en; m_peff = effect;
    end
  end

  function automatic logic [8:0] model_vec();
    int e;
    e = m_eff_rises % NEFF;
    return {2'(m_mode), (m_mode == 2) && (e != 0), (m_mode == 1), 3'(e),
            (m_mute_rises % 2) == 1, (m_ng_rises % 2) == 1};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [8:0] act, exp;
      act = {state, eff_en, vol_en, current_effect, mute_tog, noise_gate_tog};
      exp = model_vec();
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t: {state,eff_en,vol_en,eff,mute_tog,ng_tog} got %b required %b",
                 $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_eff_en"}, eff_en, 0);
    chk({tag, "_vol_en"}, vol_en, 0);
    chk({tag, "_cur_eff"}, current_effect, 0);
    chk({tag, "_mute_tog"}, mute_tog, 0);
    chk({tag, "_ng_tog"}, noise_gate_tog, 0);
  endtask

  initial begin
    int eff_seq[6];
    eff_seq = '{1, 2, 3, 4, 0, 1};

    tick(2);
    chk_reset_vals("reset");
    chk_en = 1'b1;
    nrst = 1'b1;
    tick();

    spk_aud = 8'd57; tick();
    chk("listen_state", state, 1);
    chk("listen_vol_en", vol_en, 1);
    spk_aud = 8'd0; tick();
    chk("idle_state", state, 0);
    chk("idle_vol_en", vol_en, 0);

    mic_aud = 8'd60; ptt_en = 1'b1; tick();
    chk("ptt_talk", state, 2);
    chk("ptt_eff_en0", eff_en, 0);
    ptt_en = 1'b0;
    for (int i = 0; i < H; i++) begin
      tick();
      chk($sformatf("hang_hold%0d", i), state, 2);
    end
    tick();
    chk("hang_exit", state, 0);
    mic_aud = 8'd0;

    for (int i = 0; i < 6; i++) begin
      effect = 1'b1; tick();
      chk($sformatf("eff_pulse%0d", i), current_effect, eff_seq[i]);
      effect = 1'b0; tick();
    end
    ptt_en = 1'b1; tick();
    chk("talk_eff_en1", eff_en, 1);
    ptt_en = 1'b0; tick(H + 2);
    chk("talk_eff_exit", state, 0);
    effect = 1'b1; tick(10);
    chk("eff_hold_single", current_effect, 2);
    effect = 1'b0; tick();

    ng_en = 1'b1; tick();
    chk("ng_tog_set", noise_gate_tog, 1);
    ng_en = 1'b0;
    mic_aud = 8'd80;
`ifdef TEAM_06_VAD_HYST_EN
    tick(2);
    chk("vad_talk", state, 2);
    mic_aud = 8'd60; tick(6);
    chk("vad_hyst_hold", state, 2);
    mic_aud = 8'd0; tick(H + 3);
    chk("vad_exit", state, 0);
`else
    tick();
    chk("vad_talk", state, 2);
    mic_aud = 8'd50;
    for (int i = 0; i < H; i++) begin
      tick();
      chk($sformatf("vad_hang%0d", i), state, 2);
    end
    tick();
    chk("vad_exit", state, 0);
    mic_aud = 8'd0;
`endif

    ptt_en = 1'b1; tick();
    chk("pre_mute_eff_en", eff_en, 1);
    mute = 1'b1; tick();
    chk("mute_tog_same_edge", mute_tog, 1);
    chk("mute_state_lag", state, 2);
    tick();
    chk("mute_state", state, 3);
    chk("mute_eff_en", eff_en, 0);
    chk("mute_held_once", mute_tog, 1);
    mute = 1'b0; tick();
    mute = 1'b1; tick();
    chk("unmute_tog", mute_tog, 0);
    chk("unmute_lag", state, 3);
    mute = 1'b0; tick();
    chk("unmute_idle", state, 0);
    tick();
    chk("unmute_then_talk", state, 2);
    ptt_en = 1'b0; tick(2);
    chk("mid_hang_talk", state, 2);

    #2 nrst = 1'b0;
    #1 chk_reset_vals("async_rst");
    tick();
    nrst = 1'b1; tick();
    chk("post_rst_idle", state, 0);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) ptt_en = ~ptt_en;
      if ($urandom_range(0, 15) == 0) ng_en = ~ng_en;
      if ($urandom_range(0, 5) == 0)  effect = ~effect;
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      if ($urandom_range(0, 3) == 0)  mic_aud = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0)  mic_aud = 8'($urandom_range(THR - HYS - 2, THR + 2));
      if ($urandom_range(0, 4) == 0)  spk_aud = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 799) == 0) begin
        #2 nrst = 1'b0;
        tick();
        nrst = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/team_06_voice_ctrl_fsm.md
# team_06_voice_ctrl_fsm

Parametrised successor to the team_06 audio mode FSM. It arbitrates half-duplex voice traffic between microphone and speaker paths, with push-to-talk and voice-activated talk. A programmable hang timer keeps the talk state alive after speech drops below threshold. Button-driven mute, noise-gate and effect-cycle controls use registered edge detection. The block sits between the audio front end (mic/speaker sample buses) and the effect/volume datapath, which it enables.

## Interface
Parameters:
- AUD_W, 8: audio sample width (unsigned magnitude).
- NUM_EFFECTS, 5: effect slots including 0 = bypass; minimum 2.
- VAD_THRESH, 64: voice-activation open threshold.
- VAD_HYST, 8: hysteresis margin. Used only with TEAM_06_VAD_HYST_EN; must be ≤ VAD_THRESH.
- HANG_CYCLES, 2048: cycles TALK is held after talk request drops; 0 = immediate exit.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous, active-low reset.
- mic_aud  in  AUD_W  microphone sample.
- spk_aud  in  AUD_W  incoming speaker sample.
- ng_en  in  1  noise-gate button (level, pre-synchronised).
- ptt_en  in  1  push-to-talk (level).
- effect  in  1  effect-cycle button (level).
- mute  in  1  mute button (level).
- state  out  2  current state encoding.
- eff_en  out  1  effect datapath enable.
- vol_en  out  1  speaker volume path enable.
- current_effect  out  EFF_W  selected effect, EFF_W = $clog2(NUM_EFFECTS).
- mute_tog  out  1  latched mute status.
- noise_gate_tog  out  1  latched voice-activation (noise gate) status.

## Operation
- States: IDLE=0, LISTEN=1, TALK=2, MUTE=3.
- Edge detect: each button has a prev register.
  - rise = in & ~prev.
  - mute rise toggles mute_tog.
  - ng_en rise toggles noise_gate_tog.
  - effect rise increments current_effect, wrapping NUM_EFFECTS-1 → 0.
  - Held buttons produce exactly one event.
- vad_open = noise_gate_tog & (mic_aud ≥ VAD_THRESH).
- talk_req = ptt_en | vad_open.
- spk_act = (spk_aud != 0).
- Transitions, evaluated in priority order each cycle:
  - mute_tog=1 → MUTE from any state.
  - MUTE: mute_tog=0 → IDLE.
  - IDLE:
    - talk_req → TALK, hang counter loaded with HANG_CYCLES.
    - else spk_act → LISTEN.
  - LISTEN:
    - talk_req → TALK, counter loaded. Talk pre-empts listen.
    - else !spk_act → IDLE.
  - TALK:
    - talk_req reloads the counter.
    - Otherwise the counter decrements.
    - When the counter = 0 and !talk_req: → LISTEN if spk_act, else IDLE.
- Outputs:
  - eff_en = (state==TALK) & (current_effect != 0).
  - vol_en = (state==LISTEN).
  - All outputs are registered or decoded from registers only; no input-to-output combinational path.
- Counter width: $clog2(HANG_CYCLES+1). It saturates at 0 and never wraps.
- Simultaneous button rises in one cycle are each processed independently.
- The effect rise is honoured in every state, including MUTE.

## Timing
- Reset (nrst low, asynchronous) forces:
  - state=IDLE, eff_en=0, vol_en=0, current_effect=0, mute_tog=0, noise_gate_tog=0.
  - All prev registers and the counter to 0.
- Reset asserted mid-TALK aborts the hang immediately.
- Button sampled high at edge k (prev low): toggle/effect outputs update at edge k.
- State reaction to mute_tog happens at edge k+1.
- talk_req high at edge k → state=TALK after edge k.
- After talk_req falls (first low at edge k), TALK persists through edge k+HANG_CYCLES-1 and exits at edge k+HANG_CYCLES.
  - With HANG_CYCLES=0, exit at edge k.
- talk_req re-asserting during hang reloads the counter with no state change.
- Deasserting mute returns to IDLE, not to the previous state.

## Configuration
- TEAM_06_VAD_HYST_EN defined:
  - Add a vad_latched register.
  - It opens when mic_aud ≥ VAD_THRESH.
  - It stays open while mic_aud ≥ VAD_THRESH-VAD_HYST.
  - It closes below that level.
  - It is cleared by reset and when noise_gate_tog=0.
  - vad_open = vad_latched.
- Undefined: single-threshold comparison as above; VAD_HYST is ignored.

## Structure
- Package team_06_pkg:
  - state_t enum (IDLE/LISTEN/TALK/MUTE, 2-bit).
  - Shared default constants: AUD_W_DEF, VAD_THRESH_DEF.
- Sub-module team_06_edge_det: prev register plus rise output, async active-low reset; three instances.
- The top holds the state register, hang counter, effect counter and toggles.

## Test plan
Run with HANG_CYCLES=4 and defaults otherwise.
- Reset, then spk_aud=57 with all buttons low → LISTEN next edge, vol_en=1; spk_aud=0 → IDLE, vol_en=0.
- ptt_en=1 with mic_aud=60 → TALK. Drop ptt_en → TALK held exactly 4 cycles, then IDLE; eff_en=0 since current_effect=0.
- Press effect 6 times, one-cycle pulses → current_effect sequence 1,2,3,4,0,1. Hold effect for 10 cycles → single increment. In TALK, eff_en=1 when current_effect=1.
- Press ng_en → noise_gate_tog=1. mic_aud=80 → TALK; mic_aud=50 → hang then exit. With TEAM_06_VAD_HYST_EN, mic_aud=60 after 80 keeps TALK.
- Press mute during TALK → mute_tog=1 same edge, state=MUTE next edge, eff_en=0. Press again → IDLE.
- Assert nrst=0 mid-hang asynchronously → all outputs at reset values before the next clk edge. Release → IDLE.
